mseq_bit_source: RTL

Baseband data source for the DDS modulator: generates a maximal-length pseudo-random (m-sequence) bit stream at a programmable bit rate derived from the system clock. Sits directly upstream of the phase accumulator and modulation-parameter selector. It presents the current data bit with a one-cycle `load` strobe at each bit boundary, plus a dibit/symbol output for 4-level schemes. It replaces the separate clock-divider and free-running sequence generator pair with a single-clock-domain block.

---
 rtl/mseq_bit_source.sv | 103 ++++++++++
 1 files changed

// File: rtl/mseq_bit_source.sv
// Programmable-rate m-sequence (PN5/7/9/15) bit source with load strobe and dibit output.
// Optional MSEQ_DIFF_EN: differential encoding of the emitted bit stream.
module mseq_bit_source #(
  parameter int DIV_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic [1:0]       poly_sel,
  output logic             m,
  output logic             load,
  output logic             frame,
  output logic [1:0]       sym,
  output logic             sym_vld
);

  logic [14:0]      sr, mask, mask_new, sr_shift;
  logic [DIV_W-1:0] cnt;
  logic             ph;
  logic [1:0]       psel_q;
  logic             b, fb, all_ones, all_zero, reseed, tick, m_next;

  function automatic logic [14:0] width_mask(input logic [1:0] sel);
    case (sel)
      2'b00:   return 15'h001F;
      2'b01:   return 15'h007F;
      2'b10:   return 15'h01FF;
      default: return 15'h7FFF;
    endcase
  endfunction

  always_comb begin
    mask     = width_mask(psel_q);
    mask_new = width_mask(poly_sel);
    b        = sr[14];
    fb       = sr[14] ^ sr[13];
    case (psel_q)
      2'b00:   begin b = sr[4]; fb = sr[4] ^ sr[2]; end
      2'b01:   begin b = sr[6]; fb = sr[6] ^ sr[5]; end
      2'b10:   begin b = sr[8]; fb = sr[8] ^ sr[4]; end
      default: begin b = sr[14]; fb = sr[14] ^ sr[13]; end
    endcase
    // Masking keeps the inactive upper bits at zero after every shift.
    sr_shift = {sr[13:0], fb} & mask;
    all_ones = (sr & mask) == mask;
    all_zero = (sr & mask) == 15'h0000;
    reseed   = poly_sel != psel_q;
    tick     = en && (cnt == div) && !reseed && !all_zero;
  end

`ifdef MSEQ_DIFF_EN
  // Encoder state is kept apart from m so a reseed can clear it while m is held.
  logic enc;
  always_ff @(posedge clk) begin
    if (rst)         enc <= 1'b0;
    else if (reseed) enc <= 1'b0;
    else if (tick)   enc <= m_next;
  end
  assign m_next = enc ^ b;
`else
  assign m_next = b;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sr      <= width_mask(poly_sel);
      psel_q  <= poly_sel;
      cnt     <= '0;
      ph      <= 1'b0;
      m       <= 1'b0;
      load    <= 1'b0;
      frame   <= 1'b0;
      sym     <= 2'b00;
      sym_vld <= 1'b0;
    end else begin
      load    <= 1'b0;
      sym_vld <= 1'b0;
      if (reseed) begin
        psel_q <= poly_sel;
        sr     <= mask_new;
        cnt    <= '0;
        ph     <= 1'b0;
      end else begin
        if (all_zero) sr <= mask;
        // Lowering div below cnt lets cnt run through its max and wrap.
        if (en) cnt <= (cnt == div) ? '0 : cnt + DIV_W'(1);
        if (tick) begin
          sr    <= sr_shift;
          m     <= m_next;
          load  <= 1'b1;
          frame <= all_ones;
          ph    <= ~ph;
          if (ph) begin
            sym     <= {m, m_next};
            sym_vld <= 1'b1;
          end
        end
      end
    end
  end

endmodule
